// File: rtl/rotate_seq_ctrl16.sv
// ---------------------------------------------------------------------------
// rotate_seq_ctrl16
//
// Sequential left-rotate controller. A request (i_data, i_amt) is accepted
// with a valid/ready handshake; the operand is rotated left by one bit per
// clock until the amount counter reaches zero, then the result is presented
// with a valid/ready handshake and held until the consumer takes it.
// i_abort cancels a running or completed operation and returns to idle
// without a handshake; in idle it only blocks acceptance.
//
// Ports
//   i_clk    in   1      clock, all state changes on the rising edge
//   i_rst_n  in   1      asynchronous active-low reset
//   i_valid  in   1      request present
//   o_ready  out  1      controller can accept a request (idle)
//   i_data   in   WIDTH  operand to rotate
//   i_amt    in   AMT_W  left-rotate amount, 0..WIDTH-1
//   i_abort  in   1      synchronous cancel of the current operation
//   o_valid  out  1      result present
//   i_ready  in   1      consumer accepts the result
//   o_data   out  WIDTH  rotate register (meaningful while o_valid=1)
//   o_busy   out  1      high while rotating
// ---------------------------------------------------------------------------
module rotate_seq_ctrl16 #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   input  logic [AMT_W-1:0] i_amt,
   input  logic             i_abort,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROT  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
   localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

   // Single-step left rotation: the MSB wraps into the LSB, no bits lost.
   function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[WIDTH-1]};
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] rot_r;
   logic [WIDTH-1:0] rot_nxt_s;
   logic [AMT_W-1:0] cnt_r;
   logic [AMT_W-1:0] cnt_nxt_s;
   logic             valid_r;
   logic             busy_r;
   logic             ready_r;

   // Next-state, next-register and next-counter decode.
   always_comb begin
      state_nxt_s = state_r;
      rot_nxt_s   = rot_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            // Abort in idle has no effect other than blocking acceptance.
            if (i_valid && !i_abort) begin
               rot_nxt_s = i_data;
               cnt_nxt_s = i_amt;
               if (i_amt == CNT_ZERO) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_ROT;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ROT: begin
            if (i_abort) begin
               // Cancel keeps the partially rotated register.
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               rot_nxt_s = rotl1(rot_r);
               cnt_nxt_s = cnt_r - CNT_ONE;
               // The last rotation and the move to DONE share one edge.
               if (cnt_r == CNT_ONE) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_ROT;
               end
            end
         end
         ST_DONE: begin
            if (i_abort) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
            end else if (i_ready) begin
               // Handshake completes; the next request waits for idle.
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: begin
            // Unreachable encoding: recover to a clean idle.
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, datapath and counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         rot_r   <= DATA_ZERO;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nxt_s;
         rot_r   <= rot_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Handshake/status flags registered from the next state so they are glitch-free.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         valid_r <= (state_nxt_s == ST_DONE);
         busy_r  <= (state_nxt_s == ST_ROT);
         ready_r <= (state_nxt_s == ST_IDLE);
      end
   end

   assign o_valid = valid_r;
   assign o_busy  = busy_r;
   assign o_ready = ready_r;
   assign o_data  = rot_r;

endmodule

// File: tb/tb_rotate_seq_ctrl16.sv
// ---------------------------------------------------------------------------
// tb_rotate_seq_ctrl16
//
// Directed bench for rotate_seq_ctrl16. Stimulus pushes hand-computed
// results (data, first-valid cycle, rotate amount) into a scoreboard queue;
// a monitor sampling 1 time unit after each rising edge pops an entry on
// every rising o_valid, checks data, latency and busy duration, flags any
// o_valid with nothing expected, and checks result stability while the
// consumer stalls.
// ---------------------------------------------------------------------------
module tb_rotate_seq_ctrl16;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_data;
   logic [3:0]  i_amt;
   logic        i_abort;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_data;
   logic        o_busy;

   typedef struct {
      logic [15:0] data;
      int          cyc;
      int          amt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   rotate_seq_ctrl16 #(.WIDTH(16), .AMT_W(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .i_amt   (i_amt),
      .i_abort (i_abort),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_busy  (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge counter used to measure latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: scoreboard pop on rising o_valid, stall stability, busy length.
   initial begin : monitor
      logic        prev_valid = 1'b0;
      logic [15:0] prev_data  = 16'h0000;
      logic        prev_rst   = 1'b0;
      int          busy_cnt   = 0;
      exp_t        e;
      forever begin
         @(posedge clk);
         #1;
         if (o_ready) busy_cnt = 0;
         if (o_busy) busy_cnt++;
         if (rst_n && prev_rst && prev_valid && !i_ready && !i_abort) begin
            chk("hold_valid", {31'd0, o_valid}, 32'd1);
            chk("hold_data", {16'd0, o_data}, {16'd0, prev_data});
         end
         if (o_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               chk("spurious_valid", {31'd0, o_valid}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("result_data", {16'd0, o_data}, {16'd0, e.data});
               chk("latency_cycle", cyc, e.cyc);
               chk("busy_cycles", busy_cnt, e.amt);
            end
         end
         prev_valid = o_valid;
         prev_data  = o_data;
         prev_rst   = rst_n;
      end
   end

   // Issue one request; optionally expect its result on the scoreboard.
   task automatic send(input logic [15:0] d, input logic [3:0] a,
                       input logic [15:0] exp_d, input bit push);
      int n = 0;
      @(negedge clk);
      while (!o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) chk("ready_timeout", {31'd0, o_ready}, 32'd1);
      i_valid = 1'b1;
      i_data  = d;
      i_amt   = a;
      if (push) sb_q.push_back('{exp_d, cyc + 1 + int'(a), int'(a)});
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!o_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", {31'd0, o_valid}, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_q.size() != 0 || !o_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb_q.size(), 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = 16'h0000;
      i_amt   = 4'd0;
      i_abort = 1'b0;
      i_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_data", {16'd0, o_data}, 32'd0);

      // Accept on the very first edge after reset release.
      rst_n   = 1'b1;
      i_valid = 1'b1;
      i_data  = 16'h1234;
      i_amt   = 4'd4;
      sb_q.push_back('{16'h2341, cyc + 1 + 4, 4});
      @(negedge clk);
      i_valid = 1'b0;
      drain();

      send(16'h1234, 4'd0,  16'h1234, 1'b1);
      send(16'h0001, 4'd15, 16'h8000, 1'b1);
      send(16'h8001, 4'd1,  16'h0003, 1'b1);
      send(16'hA5C3, 4'd7,  16'hE1D2, 1'b1);
      drain();

      // Consumer stall for 5 cycles with a competing request.
      i_ready = 1'b0;
      send(16'h8001, 4'd1, 16'h0003, 1'b1);
      wait_valid();
      i_valid = 1'b1;
      i_data  = 16'hFFFF;
      i_amt   = 4'd5;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_ready", {31'd0, o_ready}, 32'd0);
         chk("stall_valid", {31'd0, o_valid}, 32'd1);
         chk("stall_data", {16'd0, o_data}, 32'h0003);
      end
      i_ready = 1'b1;
      @(negedge clk);
      chk("post_hs_valid", {31'd0, o_valid}, 32'd0);
      chk("post_hs_busy", {31'd0, o_busy}, 32'd0);
      chk("post_hs_ready", {31'd0, o_ready}, 32'd1);
      i_valid = 1'b0;
      drain();

      // Abort while the result is held.
      i_ready = 1'b0;
      send(16'h0F0F, 4'd2, 16'h3C3C, 1'b1);
      wait_valid();
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("abort_done_valid", {31'd0, o_valid}, 32'd0);
      chk("abort_done_ready", {31'd0, o_ready}, 32'd1);
      chk("abort_done_data", {16'd0, o_data}, 32'h3C3C);
      i_ready = 1'b1;
      drain();

      // Reset pulse during the second rotate cycle of an amount-8 request.
      send(16'h1234, 4'd8, 16'h0000, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_data", {16'd0, o_data}, 32'd0);
      chk("midrst_valid", {31'd0, o_valid}, 32'd0);
      chk("midrst_busy", {31'd0, o_busy}, 32'd0);
      chk("midrst_ready", {31'd0, o_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("midrst_no_valid", {31'd0, o_valid}, 32'd0);

      // Abort during the third rotate cycle: two rotations have been applied.
      send(16'h1234, 4'd8, 16'h0000, 1'b0);
      @(negedge clk);
      @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      chk("abort_rot_ready", {31'd0, o_ready}, 32'd1);
      chk("abort_rot_busy", {31'd0, o_busy}, 32'd0);
      chk("abort_rot_valid", {31'd0, o_valid}, 32'd0);
      chk("abort_rot_data", {16'd0, o_data}, 32'h48D0);
      repeat (12) @(negedge clk);
      send(16'h00FF, 4'd8, 16'hFF00, 1'b1);
      drain();

      // Abort in idle blocks acceptance.
      @(negedge clk);
      i_valid = 1'b1;
      i_abort = 1'b1;
      i_data  = 16'h1234;
      i_amt   = 4'd3;
      @(negedge clk);
      i_valid = 1'b0;
      i_abort = 1'b0;
      chk("abort_idle_ready", {31'd0, o_ready}, 32'd1);
      chk("abort_idle_busy", {31'd0, o_busy}, 32'd0);
      repeat (10) @(negedge clk);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
